// File: rtl/mem_port_arbiter_if.sv
// Handshake bundle for mem_port_arbiter: IF fetch port, MEM load/store port and shared SRAM drive.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic [DATA_W-1:0] if_rdata;
   logic              if_ready;

   logic              mem_rd;
   logic              mem_wr;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ready;

   logic              sram_en;
   logic              sram_we;
   logic [ADDR_W-1:0] sram_addr;
   logic [DATA_W-1:0] sram_wdata;
   logic [DATA_W-1:0] sram_rdata;

   modport slave (
      input  if_req, if_addr, mem_rd, mem_wr, mem_addr, mem_wdata, sram_rdata,
      output if_rdata, if_ready, mem_rdata, mem_ready,
      output sram_en, sram_we, sram_addr, sram_wdata
   );

   modport master (
      output if_req, if_addr, mem_rd, mem_wr, mem_addr, mem_wdata, sram_rdata,
      input  if_rdata, if_ready, mem_rdata, mem_ready,
      input  sram_en, sram_we, sram_addr, sram_wdata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates IF and MEM pipeline ports onto one single-port SRAM with WAIT_CYCLES access length.
// Optional one-entry posted write buffer enabled by defining MEM_WRITE_BUFFER_EN.
module mem_port_arbiter #(
   parameter int WAIT_CYCLES = 2,
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32
) (
   input  logic              clk,
   input  logic              rst,
   mem_port_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, IF_ACC, MEM_ACC, DRAIN} state_t;

   localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

   state_t            state_reg, state_next;
   logic [3:0]        cnt_reg, cnt_next;
   logic              sram_en_reg, sram_en_next;
   logic              sram_we_reg, sram_we_next;
   logic [ADDR_W-1:0] sram_addr_reg, sram_addr_next;
   logic [DATA_W-1:0] sram_wdata_reg, sram_wdata_next;
   logic [DATA_W-1:0] if_rdata_reg, if_rdata_next;
   logic [DATA_W-1:0] mem_rdata_reg, mem_rdata_next;
   logic              if_ready_reg, if_ready_next;
   logic              mem_ready_reg, mem_ready_next;
   logic              if_elig, mem_elig;
`ifdef MEM_WRITE_BUFFER_EN
   logic              wb_valid_reg, wb_valid_next;
   logic [ADDR_W-1:0] wb_addr_reg, wb_addr_next;
   logic [DATA_W-1:0] wb_data_reg, wb_data_next;
`endif

   // A requester whose ready is high this cycle is done; its still-high req must not re-grant.
   assign if_elig  = bus.if_req & ~if_ready_reg;
   assign mem_elig = (bus.mem_rd | bus.mem_wr) & ~mem_ready_reg;

   always_comb begin
      state_next      = state_reg;
      cnt_next        = cnt_reg;
      sram_en_next    = sram_en_reg;
      sram_we_next    = sram_we_reg;
      sram_addr_next  = sram_addr_reg;
      sram_wdata_next = sram_wdata_reg;
      if_rdata_next   = if_rdata_reg;
      mem_rdata_next  = mem_rdata_reg;
      if_ready_next   = 1'b0;
      mem_ready_next  = 1'b0;
`ifdef MEM_WRITE_BUFFER_EN
      wb_valid_next   = wb_valid_reg;
      wb_addr_next    = wb_addr_reg;
      wb_data_next    = wb_data_reg;
`endif
      case (state_reg)
         IDLE: begin
`ifdef MEM_WRITE_BUFFER_EN
            if (mem_elig && bus.mem_wr && !wb_valid_reg) begin
               // Posted store: buffer it and acknowledge without touching the SRAM.
               wb_valid_next  = 1'b1;
               wb_addr_next   = bus.mem_addr;
               wb_data_next   = bus.mem_wdata;
               mem_ready_next = 1'b1;
            end else if (mem_elig && !bus.mem_wr &&
                         !(wb_valid_reg && bus.mem_addr == wb_addr_reg)) begin
               state_next     = MEM_ACC;
               cnt_next       = CNT_LOAD;
               sram_en_next   = 1'b1;
               sram_we_next   = 1'b0;
               sram_addr_next = bus.mem_addr;
            end else if (wb_valid_reg) begin
               state_next      = DRAIN;
               cnt_next        = CNT_LOAD;
               sram_en_next    = 1'b1;
               sram_we_next    = 1'b1;
               sram_addr_next  = wb_addr_reg;
               sram_wdata_next = wb_data_reg;
            end else if (if_elig) begin
`else
            if (mem_elig) begin
               state_next      = MEM_ACC;
               cnt_next        = CNT_LOAD;
               sram_en_next    = 1'b1;
               sram_we_next    = bus.mem_wr;
               sram_addr_next  = bus.mem_addr;
               sram_wdata_next = bus.mem_wdata;
            end else if (if_elig) begin
`endif
               state_next     = IF_ACC;
               cnt_next       = CNT_LOAD;
               sram_en_next   = 1'b1;
               sram_we_next   = 1'b0;
               sram_addr_next = bus.if_addr;
            end
         end
         IF_ACC, MEM_ACC, DRAIN: begin
            if (cnt_reg == 4'd0) begin
               state_next   = IDLE;
               sram_en_next = 1'b0;
               sram_we_next = 1'b0;
               if (state_reg == IF_ACC) begin
                  if_rdata_next = bus.sram_rdata;
                  if_ready_next = 1'b1;
               end else if (state_reg == MEM_ACC) begin
                  if (!sram_we_reg) mem_rdata_next = bus.sram_rdata;
                  mem_ready_next = 1'b1;
               end else begin
`ifdef MEM_WRITE_BUFFER_EN
                  wb_valid_next = 1'b0;
`endif
               end
            end else begin
               cnt_next = cnt_reg - 4'd1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg      <= IDLE;
         cnt_reg        <= '0;
         sram_en_reg    <= 1'b0;
         sram_we_reg    <= 1'b0;
         sram_addr_reg  <= '0;
         sram_wdata_reg <= '0;
         if_rdata_reg   <= '0;
         mem_rdata_reg  <= '0;
         if_ready_reg   <= 1'b0;
         mem_ready_reg  <= 1'b0;
`ifdef MEM_WRITE_BUFFER_EN
         wb_valid_reg   <= 1'b0;
         wb_addr_reg    <= '0;
         wb_data_reg    <= '0;
`endif
      end else begin
         state_reg      <= state_next;
         cnt_reg        <= cnt_next;
         sram_en_reg    <= sram_en_next;
         sram_we_reg    <= sram_we_next;
         sram_addr_reg  <= sram_addr_next;
         sram_wdata_reg <= sram_wdata_next;
         if_rdata_reg   <= if_rdata_next;
         mem_rdata_reg  <= mem_rdata_next;
         if_ready_reg   <= if_ready_next;
         mem_ready_reg  <= mem_ready_next;
`ifdef MEM_WRITE_BUFFER_EN
         wb_valid_reg   <= wb_valid_next;
         wb_addr_reg    <= wb_addr_next;
         wb_data_reg    <= wb_data_next;
`endif
      end
   end

   assign bus.sram_en    = sram_en_reg;
   assign bus.sram_we    = sram_we_reg;
   assign bus.sram_addr  = sram_addr_reg;
   assign bus.sram_wdata = sram_wdata_reg;
   assign bus.if_rdata   = if_rdata_reg;
   assign bus.if_ready   = if_ready_reg;
   assign bus.mem_rdata  = mem_rdata_reg;
   assign bus.mem_ready  = mem_ready_reg;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, reset/buffer sequences and
// a randomized run against a cycle-arithmetic reference model.
module tb_mem_port_arbiter;
   localparam int W = 2;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_total = 0;
   int   n_pass  = 0;

   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   mem_port_arbiter #(.WAIT_CYCLES(W), .ADDR_W(32), .DATA_W(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] init_val(input int i);
      if (i == 4)  return 32'hE3A0_1005;
      if (i == 64) return 32'h1234_5678;
      return 32'hC0DE_0000 ^ (i * 32'h0001_0101);
   endfunction

   // SRAM model: untouched words read their initial pattern.
   logic [31:0] sram_mem  [0:255];
   bit          sram_seen [0:255];
   logic [7:0]  sram_idx;
   assign sram_idx = bus.sram_addr[9:2];
   assign bus.sram_rdata = (bus.sram_en && !bus.sram_we)
                         ? (sram_seen[sram_idx] ? sram_mem[sram_idx] : init_val(int'(sram_idx)))
                         : 32'hDEAD_BEEF;
   always @(posedge clk) begin
      if (bus.sram_en && bus.sram_we) begin
         sram_mem[sram_idx]  <= bus.sram_wdata;
         sram_seen[sram_idx] <= 1'b1;
      end
   end

   logic [31:0] model_mem [0:255];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   typedef struct {
      logic        if_req;
      logic [31:0] if_addr;
      logic        mem_rd;
      logic        mem_wr;
      logic [31:0] mem_addr;
      logic [31:0] mem_wdata;
      int          exp_if_cyc;
      int          exp_mem_cyc;
      logic [31:0] exp_if_data;
      logic [31:0] exp_mem_data;
      logic [15:0] exp_en;
      logic [15:0] exp_we;
   } vec_t;

`ifdef MEM_WRITE_BUFFER_EN
   localparam int          ST_CYC = 1;
   localparam logic [15:0] ST_EN  = 16'h000C;
   localparam logic [15:0] ST_WE  = 16'h000C;
`else
   localparam int          ST_CYC = 3;
   localparam logic [15:0] ST_EN  = 16'h0006;
   localparam logic [15:0] ST_WE  = 16'h0006;
`endif

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin : main
      vec_t vecs [5];
      int   if_cyc, mem_cyc, cyc, cyc2;
      logic [31:0] if_dat, mem_dat;
      logic [15:0] en_m, we_m;
      logic seen;

      for (int i = 0; i < 256; i++) model_mem[i] = init_val(i);

      vecs[0] = '{1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 3, -1,
                  32'hE3A0_1005, 32'h0, 16'h0006, 16'h0000};
      vecs[1] = '{1'b1, 32'h10, 1'b1, 1'b0, 32'h100, 32'h0, 6, 3,
                  32'hE3A0_1005, 32'h1234_5678, 16'h0036, 16'h0000};
      vecs[2] = '{1'b0, 32'h0, 1'b0, 1'b1, 32'h200, 32'h55, -1, ST_CYC,
                  32'h0, 32'h0, ST_EN, ST_WE};
      vecs[3] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h200, 32'h0, -1, 3,
                  32'h0, 32'h55, 16'h0006, 16'h0000};
      vecs[4] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h104, 32'hA5A5, -1, ST_CYC,
                  32'h0, 32'h0, ST_EN, ST_WE};

      bus.if_req = 1'b0; bus.if_addr = '0;
      bus.mem_rd = 1'b0; bus.mem_wr = 1'b0; bus.mem_addr = '0; bus.mem_wdata = '0;

      // Reset state
      repeat (2) @(negedge clk);
      chk("reset_sram_en",   32'(bus.sram_en),   32'd0);
      chk("reset_sram_we",   32'(bus.sram_we),   32'd0);
      chk("reset_if_ready",  32'(bus.if_ready),  32'd0);
      chk("reset_mem_ready", 32'(bus.mem_ready), 32'd0);
      chk("reset_sram_addr", bus.sram_addr, 32'd0);
      chk("reset_if_rdata",  bus.if_rdata,  32'd0);
      rst = 1'b1;
      @(negedge clk);

      // Directed vector table: inputs raised in cycle 0, outputs observed for 12 cycles
      for (int v = 0; v < 5; v++) begin
         if_cyc = -1; mem_cyc = -1; if_dat = '0; mem_dat = '0; en_m = '0; we_m = '0;
         @(negedge clk);
         bus.if_req   = vecs[v].if_req;    bus.if_addr   = vecs[v].if_addr;
         bus.mem_rd   = vecs[v].mem_rd;    bus.mem_wr    = vecs[v].mem_wr;
         bus.mem_addr = vecs[v].mem_addr;  bus.mem_wdata = vecs[v].mem_wdata;
         for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (bus.sram_en) en_m[n] = 1'b1;
            if (bus.sram_en && bus.sram_we) we_m[n] = 1'b1;
            if (bus.if_ready && if_cyc < 0) begin
               if_cyc = n; if_dat = bus.if_rdata; bus.if_req = 1'b0;
            end
            if (bus.mem_ready && mem_cyc < 0) begin
               mem_cyc = n; mem_dat = bus.mem_rdata; bus.mem_rd = 1'b0; bus.mem_wr = 1'b0;
            end
         end
         bus.if_req = 1'b0; bus.mem_rd = 1'b0; bus.mem_wr = 1'b0;
         $display("vec %0d: if_ready@%0d mem_ready@%0d en=%04h we=%04h", v, if_cyc, mem_cyc, en_m, we_m);
         chk($sformatf("vec%0d_if_cycle", v),  32'(if_cyc),  32'(vecs[v].exp_if_cyc));
         chk($sformatf("vec%0d_mem_cycle", v), 32'(mem_cyc), 32'(vecs[v].exp_mem_cyc));
         chk($sformatf("vec%0d_sram_en", v),   32'(en_m),    32'(vecs[v].exp_en));
         chk($sformatf("vec%0d_sram_we", v),   32'(we_m),    32'(vecs[v].exp_we));
         if (vecs[v].exp_if_cyc >= 0)
            chk($sformatf("vec%0d_if_rdata", v), if_dat, vecs[v].exp_if_data);
         if (vecs[v].exp_mem_cyc >= 0 && !vecs[v].mem_wr)
            chk($sformatf("vec%0d_mem_rdata", v), mem_dat, vecs[v].exp_mem_data);
         if (vecs[v].mem_wr) model_mem[vecs[v].mem_addr[9:2]] = vecs[v].mem_wdata;
      end

      // Reset in cycle 2 of a MEM read aborts it; the held request then completes in 3 cycles
      @(negedge clk);
      bus.mem_rd = 1'b1; bus.mem_addr = 32'h100;
      repeat (2) @(negedge clk);
      chk("rst_pre_sram_en", 32'(bus.sram_en), 32'd1);
      rst = 1'b0;
      #1;
      chk("rst_abort_sram_en", 32'(bus.sram_en),   32'd0);
      chk("rst_abort_ready",   32'(bus.mem_ready), 32'd0);
      chk("rst_clear_mem_rdata", bus.mem_rdata, 32'd0);
      chk("rst_clear_if_rdata",  bus.if_rdata,  32'd0);
      seen = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (bus.mem_ready) seen = 1'b1;
      end
      chk("rst_no_ready", 32'(seen), 32'd0);
      rst = 1'b1;
      cyc = -1; mem_dat = '0;
      for (int n = 1; n <= 10; n++) begin
         @(negedge clk);
         if (bus.mem_ready && cyc < 0) begin
            cyc = n; mem_dat = bus.mem_rdata; bus.mem_rd = 1'b0;
         end
      end
      bus.mem_rd = 1'b0;
      $display("reset resume: mem_ready@%0d data=%08h", cyc, mem_dat);
      chk("rst_resume_cycle", 32'(cyc), 32'd3);
      chk("rst_resume_rdata", mem_dat, 32'h1234_5678);

`ifdef MEM_WRITE_BUFFER_EN
      // Store then same-address load: buffer drains before the load reads the SRAM
      @(negedge clk);
      bus.mem_wr = 1'b1; bus.mem_addr = 32'h300; bus.mem_wdata = 32'h77;
      cyc = -1; cyc2 = -1; mem_dat = '0;
      for (int n = 1; n <= 15; n++) begin
         @(negedge clk);
         if (bus.mem_ready) begin
            if (cyc < 0) begin
               cyc = n; bus.mem_wr = 1'b0; bus.mem_rd = 1'b1;
            end else if (cyc2 < 0) begin
               cyc2 = n; mem_dat = bus.mem_rdata; bus.mem_rd = 1'b0;
            end
         end
      end
      bus.mem_rd = 1'b0; bus.mem_wr = 1'b0;
      $display("wbuf seq: store ready@%0d load ready@%0d data=%08h", cyc, cyc2, mem_dat);
      chk("wb_store_cycle", 32'(cyc),  32'd1);
      chk("wb_load_cycle",  32'(cyc2), 32'd7);
      chk("wb_load_rdata",  mem_dat,   32'h77);
`else
      begin : rnd
         int free_at, if_due, mem_due;
         logic if_pend, mem_pend, cur_we, mem_is_rd, in_win;
         logic [31:0] if_exp, mem_exp, cur_addr;
         int op;
         @(negedge clk);
         free_at = 0; if_due = -1; mem_due = -1;
         if_pend = 1'b0; mem_pend = 1'b0; cur_we = 1'b0; mem_is_rd = 1'b0;
         if_exp = '0; mem_exp = '0; cur_addr = '0;
         for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            chk("rnd_if_ready", 32'(bus.if_ready), 32'(c == if_due));
            if (c == if_due) begin
               chk("rnd_if_rdata", bus.if_rdata, if_exp);
               if_pend = 1'b0; bus.if_req = 1'b0;
            end
            chk("rnd_mem_ready", 32'(bus.mem_ready), 32'(c == mem_due));
            if (c == mem_due) begin
               if (mem_is_rd) chk("rnd_mem_rdata", bus.mem_rdata, mem_exp);
               mem_pend = 1'b0; bus.mem_rd = 1'b0; bus.mem_wr = 1'b0;
            end
            in_win = (c >= free_at - W) && (c < free_at);
            chk("rnd_sram_en", 32'(bus.sram_en), 32'(in_win));
            chk("rnd_sram_we", 32'(bus.sram_we), 32'(in_win && cur_we));
            if (in_win) chk("rnd_sram_addr", bus.sram_addr, cur_addr);

            // New requests may be raised even in a ready cycle; the arbiter must ignore those then
            if (!if_pend && $urandom_range(2) == 0) begin
               if_pend = 1'b1; bus.if_req = 1'b1;
               bus.if_addr = 32'($urandom_range(255)) << 2;
            end
            if (!mem_pend && $urandom_range(2) == 0) begin
               op = int'($urandom_range(2));
               mem_pend = 1'b1;
               bus.mem_rd = (op != 1);
               bus.mem_wr = (op != 0);
               bus.mem_addr  = 32'($urandom_range(255)) << 2;
               bus.mem_wdata = $urandom;
            end

            // Reference: one access at a time, WAIT_CYCLES+1 latency, MEM before IF
            if (c >= free_at) begin
               if (mem_pend && c != mem_due) begin
                  mem_due = c + W + 1; free_at = mem_due;
                  cur_addr = bus.mem_addr; cur_we = bus.mem_wr; mem_is_rd = !bus.mem_wr;
                  if (bus.mem_wr) model_mem[bus.mem_addr[9:2]] = bus.mem_wdata;
                  else            mem_exp = model_mem[bus.mem_addr[9:2]];
               end else if (if_pend && c != if_due) begin
                  if_due = c + W + 1; free_at = if_due;
                  cur_addr = bus.if_addr; cur_we = 1'b0;
                  if_exp = model_mem[bus.if_addr[9:2]];
               end
            end
         end
         bus.if_req = 1'b0; bus.mem_rd = 1'b0; bus.mem_wr = 1'b0;
         $display("random run: %0d cycles done", 400);
      end
`endif

      repeat (5) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 2, SRAM access length in cycles (legal 1..15).
REQ-002 SHALL have parameter ADDR_W, default 32, address width.
REQ-003 SHALL have parameter DATA_W, default 32, data width.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 if_req  in  1  instruction-fetch request; held high until if_ready.
REQ-007 if_addr  in  ADDR_W  fetch address; stable while if_req is high.
REQ-008 if_rdata  out  DATA_W  fetched word; valid only when if_ready is high.
REQ-009 if_ready  out  1  one-cycle fetch-complete pulse; IF stage freezes while if_req=1 and if_ready=0.
REQ-010 mem_rd, mem_wr  in  1 each  MEM-stage load and store requests; held high until mem_ready.
REQ-011 mem_addr  in  ADDR_W, mem_wdata  in  DATA_W  load/store address and store data.
REQ-012 mem_rdata  out  DATA_W  load data, valid with mem_ready; mem_ready  out  1  one-cycle completion pulse.
REQ-013 sram_en  out  1, sram_we  out  1, sram_addr  out  ADDR_W, sram_wdata  out  DATA_W  shared single-port SRAM drive.
REQ-014 sram_rdata  in  DATA_W  SRAM read data; valid in the last access cycle.

Function
REQ-015 SHALL implement FSM states IDLE, IF_ACC, MEM_ACC and DRAIN.
REQ-016 IDLE grant priority SHALL be: MEM read or write, then DRAIN, then IF. The older pipeline instruction wins.
REQ-017 If mem_rd and mem_wr are both high, the access SHALL be treated as a write.
REQ-018 On a grant in cycle t, the FSM SHALL enter the ACC state and hold sram_en=1 with stable address, data and we in cycles t+1..t+WAIT_CYCLES.
REQ-019 The counter SHALL load WAIT_CYCLES-1 on grant and decrement each ACC cycle. When it reaches zero, sram_rdata SHALL be registered into the requester's rdata.
REQ-020 The FSM SHALL then return to IDLE with the requester's ready pulsed in cycle t+WAIT_CYCLES+1. Total latency is WAIT_CYCLES+1 cycles.
REQ-021 In the cycle its ready is high, the completed requester's req SHALL be ignored for granting. The other requester MAY be granted in that same cycle.
REQ-022 Outside ACC and DRAIN, sram_en and sram_we SHALL be 0.
REQ-023 if_rdata and mem_rdata SHALL hold their last value until the next completion.
REQ-024 A request deasserted before ready SHALL be a protocol violation. The arbiter SHALL still complete the access and pulse ready.

Reset
REQ-025 On rst low, the block SHALL immediately drive: state IDLE, counter 0, sram_en=0, sram_we=0, if_ready=0, mem_ready=0.
REQ-026 On rst low, the block SHALL also clear sram_addr, sram_wdata, if_rdata and mem_rdata to 0 and empty the write buffer.
REQ-027 Reset mid-access SHALL abort the access with no ready pulse. Arbitration SHALL resume on the first edge after rst returns high.

Configuration
REQ-028 With macro MEM_WRITE_BUFFER_EN defined, the block SHALL contain a one-entry posted write buffer (valid flag, address, data).
REQ-029 Store with buffer empty: capture in cycle t, pulse mem_ready at t+1, no SRAM access at accept.
REQ-030 Store with buffer full: wait for DRAIN to complete, then capture.
REQ-031 DRAIN SHALL perform a WAIT_CYCLES write from the buffer with no ready pulse and clear the valid flag on completion.
REQ-032 A load whose address equals the buffered address SHALL force DRAIN first. A load to a different address SHALL bypass the buffer.
REQ-033 Without MEM_WRITE_BUFFER_EN, stores SHALL use MEM_ACC with sram_we=1 and WAIT_CYCLES+1 latency. DRAIN SHALL be unreachable.

Verification (WAIT_CYCLES=2)
REQ-034 Fetch only: if_req at cycle 0, addr 0x10, SRAM returns 0xE3A01005 -> sram_en high cycles 1-2; if_ready and if_rdata=0xE3A01005 at cycle 3.
REQ-035 Conflict: if_req and mem_rd (addr 0x100) at cycle 0 -> MEM served, mem_ready at cycle 3; IF granted at cycle 3, if_ready at cycle 6.
REQ-036 Reset: rst low at cycle 2 of a MEM access -> sram_en=0 immediately, no mem_ready; after release, a held request completes in 3 cycles.
REQ-037 Buffer enabled: store 0x55 to 0x200 at cycle 0 -> mem_ready at cycle 1; DRAIN writes 0x55 to SRAM 0x200.
REQ-038 Buffer enabled: store to 0x200, then load from 0x200 while the buffer is still full -> DRAIN completes first, then the load returns 0x55.
REQ-039 Buffer disabled: store at cycle 0 -> sram_we high cycles 1-2; mem_ready at cycle 3.
